// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WR    = 2'b01,
        RD    = 2'b10,
        WR_RD = 2'b11
    } fifo_op_e;

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read data.
module fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count and registered status pulses.
// Optional macro FIFO_PROG_THRESH_EN adds runtime af_level/ae_level inputs.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int  FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int  AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int  AE_LEVEL   = 1,
    localparam int CW         = $clog2(FIFO_DEPTH + 1),
    localparam int PW         = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
`ifdef FIFO_PROG_THRESH_EN
    input  logic [CW-1:0]         af_level,
    input  logic [CW-1:0]         ae_level,
`endif
    output logic [CW-1:0]         count
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ack_q, overflow_q, underflow_q;
    logic          wr_acc, rd_acc;
    logic [CW-1:0] af_lvl, ae_lvl;
    fifo_op_e      op;

`ifdef FIFO_PROG_THRESH_EN
    function automatic logic [CW-1:0] clamp_lvl(input logic [CW-1:0] lvl);
        if (lvl < CW'(1)) return CW'(1);
        if (lvl > CW'(FIFO_DEPTH - 1)) return CW'(FIFO_DEPTH - 1);
        return lvl;
    endfunction

    assign af_lvl = clamp_lvl(af_level);
    assign ae_lvl = clamp_lvl(ae_level);
`else
    assign af_lvl = CW'(AF_LEVEL);
    assign ae_lvl = CW'(AE_LEVEL);
`endif

    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= af_lvl) && !full;
    assign almostempty = (count_q <= ae_lvl) && !empty;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;
    assign op     = fifo_op_e'({rd_acc, wr_acc});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = PW'(ptr_next(32'(wr_ptr_q), 32'(FIFO_DEPTH)));
        end
        if (rd_acc) begin
            rd_ptr_d = PW'(ptr_next(32'(rd_ptr_q), 32'(FIFO_DEPTH)));
        end
        case (op)
            WR:      count_d = count_q + CW'(1);
            RD:      count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_acc;
            overflow_q  <= wr_en && full;
            underflow_q <= rd_en && empty;
        end
    end

    // Read data register lives in the memory; no write-to-read bypass when empty.
    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (data_out)
    );

    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign count     = count_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench: depth-8 and depth-6 FIFOs driven in lockstep against a queue-based model.
module tb_fifo_sync_param;

    typedef struct {
        logic [15:0] dout;
        bit          ack, ovf, unf, full, empty, af, ae;
        int          cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] data_in = '0;

    logic [15:0] d8_dout, d6_dout;
    logic        d8_ack, d8_ovf, d8_unf, d8_full, d8_empty, d8_af, d8_ae;
    logic        d6_ack, d6_ovf, d6_unf, d6_full, d6_empty, d6_af, d6_ae;
    logic [3:0]  d8_cnt;
    logic [2:0]  d6_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    logic [15:0] mq     [2][$];
    exp_t        sb     [2][$];
    logic [15:0] dout_m [2];

    always #5 clk = ~clk;

    fifo_sync_param u_d8 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(d8_dout), .wr_ack(d8_ack), .overflow(d8_ovf), .underflow(d8_unf),
        .full(d8_full), .empty(d8_empty), .almostfull(d8_af), .almostempty(d8_ae),
`ifdef FIFO_PROG_THRESH_EN
        .af_level(4'd7), .ae_level(4'd1),
`endif
        .count(d8_cnt)
    );

    fifo_sync_param #(.FIFO_DEPTH(6)) u_d6 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(d6_dout), .wr_ack(d6_ack), .overflow(d6_ovf), .underflow(d6_unf),
        .full(d6_full), .empty(d6_empty), .almostfull(d6_af), .almostempty(d6_ae),
`ifdef FIFO_PROG_THRESH_EN
        .af_level(3'd5), .ae_level(3'd1),
`endif
        .count(d6_cnt)
    );

    function automatic int dep(input int i);
        return (i == 0) ? 8 : 6;
    endfunction

    // Flags straight from the occupancy rules: AF at depth-1, AE at 1.
    function automatic exp_t with_flags(input exp_t e, input int n, input int dd);
        exp_t r;
        r       = e;
        r.cnt   = n;
        r.full  = (n == dd);
        r.empty = (n == 0);
        r.af    = (n >= dd - 1) && (n != dd);
        r.ae    = (n <= 1) && (n != 0);
        return r;
    endfunction

    function automatic void model_step(input int i, input logic w, input logic r, input logic [15:0] d);
        exp_t e;
        int   n;
        int   dd;
        dd    = dep(i);
        n     = mq[i].size();
        e.ack = w && (n != dd);
        e.ovf = w && (n == dd);
        e.unf = r && (n == 0);
        if (r && n != 0) dout_m[i] = mq[i].pop_front();
        if (w && n != dd) mq[i].push_back(d);
        e.dout = dout_m[i];
        sb[i].push_back(with_flags(e, mq[i].size(), dd));
    endfunction

    function automatic void model_reset(input int i);
        exp_t e;
        mq[i].delete();
        dout_m[i] = '0;
        e.dout = '0;
        e.ack  = 1'b0;
        e.ovf  = 1'b0;
        e.unf  = 1'b0;
        sb[i].push_back(with_flags(e, 0, dep(i)));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string p, input exp_t e, input logic [15:0] dout,
                              input logic ack, input logic ovf, input logic unf,
                              input logic full, input logic empty, input logic af,
                              input logic ae, input int cnt);
        chk({p, ".data_out"}, int'(dout), int'(e.dout));
        chk({p, ".wr_ack"}, int'(ack), int'(e.ack));
        chk({p, ".overflow"}, int'(ovf), int'(e.ovf));
        chk({p, ".underflow"}, int'(unf), int'(e.unf));
        chk({p, ".full"}, int'(full), int'(e.full));
        chk({p, ".empty"}, int'(empty), int'(e.empty));
        chk({p, ".almostfull"}, int'(af), int'(e.af));
        chk({p, ".almostempty"}, int'(ae), int'(e.ae));
        chk({p, ".count"}, cnt, e.cnt);
    endtask

    // Monitor: wakes on every clock edge and on async reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (sb[0].size() > 0) begin
                e = sb[0].pop_front();
                check_inst("d8", e, d8_dout, d8_ack, d8_ovf, d8_unf, d8_full, d8_empty,
                           d8_af, d8_ae, int'(d8_cnt));
            end
            if (sb[1].size() > 0) begin
                e = sb[1].pop_front();
                check_inst("d6", e, d6_dout, d6_ack, d6_ovf, d6_unf, d6_full, d6_empty,
                           d6_af, d6_ae, int'(d6_cnt));
            end
        end
    end

    task automatic cycle(input logic w, input logic r, input logic [15:0] d);
        @(negedge clk);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        for (int i = 0; i < 2; i++) model_step(i, w, r, d);
    endtask

    // Reset lands between clock edges so the check proves it is asynchronous.
    task automatic do_reset();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) model_reset(i);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int bias;
        do_reset();
        repeat (2) cycle(1'b0, 1'b0, 16'h0);

        for (int k = 1; k <= 9; k++) cycle(1'b1, 1'b0, 16'(k));
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b1, 16'h0);

        cycle(1'b1, 1'b1, 16'h00A0);
        for (int k = 1; k <= 3; k++) cycle(1'b1, 1'b0, 16'(16'h00B0 + k));
        cycle(1'b1, 1'b1, 16'h00C0);
        for (int k = 1; k <= 4; k++) cycle(1'b1, 1'b0, 16'(16'h00C0 + k));
        cycle(1'b1, 1'b1, 16'h00D0);
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b1, 16'h0);

        for (int k = 1; k <= 5; k++) cycle(1'b1, 1'b0, 16'(16'h00E0 + k));
        do_reset();
        cycle(1'b1, 1'b0, 16'h5A5A);
        cycle(1'b0, 1'b1, 16'h0);
        cycle(1'b0, 1'b0, 16'h0);

        for (int k = 0; k < 600; k++) begin
            bias = ((k / 75) % 2 == 0) ? 70 : 30;
            cycle(($urandom_range(0, 99) < bias) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 100 - bias) ? 1'b1 : 1'b0,
                  16'($urandom));
        end

        repeat (3) cycle(1'b0, 1'b0, 16'h0);
        repeat (2) @(negedge clk);
        n_vec++;
        if (sb[0].size() != 0 || sb[1].size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending %0d/%0d, expected 0/0", sb[0].size(), sb[1].size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO: generalised width, depth and almost-full/almost-empty thresholds, with an occupancy count output. Registered per-request status pulses: write acknowledge, overflow, underflow. Drop-in successor to the fixed-size synchronous FIFO in the datapath. Checked by the existing scoreboard counters in `shared_pkg`: wr_ack, full, empty, almostfull, almostempty, overflow, underflow, dout.

## Interface
Parameters:
- `FIFO_WIDTH`, default 16: data width in bits, ≥1.
- `FIFO_DEPTH`, default 8: entries, ≥2; need not be a power of two.
- `AF_LEVEL`, default `FIFO_DEPTH-1`: almostfull threshold, 1..`FIFO_DEPTH-1`.
- `AE_LEVEL`, default 1: almostempty threshold, 1..`FIFO_DEPTH-1`.

Ports (`CW` = `$clog2(FIFO_DEPTH+1)`):
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_in` in `FIFO_WIDTH`: write data.
- `wr_en` in 1: write request.
- `rd_en` in 1: read request.
- `data_out` out `FIFO_WIDTH`: read data, registered.
- `wr_ack` out 1: registered; previous cycle's write was accepted.
- `overflow` out 1: registered; previous cycle's write was rejected because the FIFO was full.
- `underflow` out 1: registered; previous cycle's read was rejected because the FIFO was empty.
- `full`, `empty`, `almostfull`, `almostempty` out 1: combinational from `count`.
- `count` out `CW`: current occupancy, 0..`FIFO_DEPTH`.

## Operation
- State: `wr_ptr` and `rd_ptr`, each `$clog2(FIFO_DEPTH)` bits; `count` (`CW` bits); storage array.
- Pointer advance: increment by 1; at `FIFO_DEPTH-1` wrap to 0 (explicit compare, not modulo-2^n).
- Write accepted when `wr_en && !full`:
  - `data_in` is stored at `wr_ptr`; `wr_ptr` advances.
  - Next cycle: `wr_ack=1`, `overflow=0`.
- Write rejected when `wr_en && full`:
  - No state change.
  - Next cycle: `overflow=1`, `wr_ack=0`.
- No write request (`!wr_en`): next cycle `wr_ack=0`, `overflow=0`.
- Read accepted when `rd_en && !empty`:
  - `data_out` ← entry at `rd_ptr`; `rd_ptr` advances.
  - Next cycle: `underflow=0`.
- Read rejected when `rd_en && empty`:
  - `data_out` holds its value.
  - Next cycle: `underflow=1`.
- No read request (`!rd_en`): `data_out` holds; next cycle `underflow=0`.
- Simultaneous `wr_en && rd_en`:
  - Not empty and not full: both accepted; `count` unchanged.
  - Empty: write accepted, read rejected (`underflow=1`); `count` +1. No bypass of write data to `data_out`.
  - Full: read accepted, write rejected (`overflow=1`); `count` −1.
- Flags:
  - `full` = (`count`==`FIFO_DEPTH`); `empty` = (`count`==0).
  - `almostfull` = (`count` ≥ `AF_LEVEL`) && !`full`.
  - `almostempty` = (`count` ≤ `AE_LEVEL`) && !`empty`.
- Reset (`rst_n` low, any time including mid-burst):
  - Pointers, `count`, `data_out`, `wr_ack`, `overflow`, `underflow` → 0.
  - Flags follow from `count`=0: `empty=1`, `full=0`, `almostfull=0`, `almostempty=0`.
  - Storage contents are not reset.

## Timing
- Write-to-read latency: data written in cycle N is readable with `rd_en` in cycle N+1 and appears on `data_out` after the N+1 edge.
- `wr_ack`, `overflow`, `underflow`, `data_out`: one cycle after the request edge.
- `count` and the flags: update on the accepting edge, visible in the same cycle after that edge.
- Reset: assertion clears state immediately, without waiting for `clk`. First accepted request is on the first rising edge after `rst_n` is high.

## Configuration
- `FIFO_PROG_THRESH_EN` defined:
  - Adds inputs `af_level` and `ae_level` (each `CW` bits), replacing `AF_LEVEL`/`AE_LEVEL` in the flag equations.
  - The levels are used combinationally; changing them takes effect in the same cycle.
  - Values outside 1..`FIFO_DEPTH-1` are clamped to that range.
- Not defined: the ports are absent and the parameters are used.

## Structure
- Package `fifo_pkg` holds:
  - Default constants: `FIFO_WIDTH_DEF`=16, `FIFO_DEPTH_DEF`=8.
  - Function `ptr_next(ptr, depth)` implementing the wrap.
  - `fifo_op_e` enum {IDLE, WR, RD, WR_RD}, for the bench and coverage.
- One sub-module, `fifo_mem`: simple dual-port register array with synchronous write and synchronous read-data register.
- Pointers, `count` and flag logic stay in the top level.

## Test plan
Parameters DEPTH=8, WIDTH=16 unless stated.
- Reset then idle → `empty=1`, `count=0`, `data_out=0`, all pulses 0.
- Write 0x0001..0x0008 → `wr_ack=1` each cycle; `almostfull=1` at `count=7`; `full=1` at 8. A 9th write → `overflow=1`, `count` stays 8.
- Read 8 entries → `data_out` 0x0001..0x0008 in order; `almostempty=1` at `count=1`. A 9th read → `underflow=1`, `data_out` holds 0x0008.
- Simultaneous `wr_en` and `rd_en` at `count=0`, 4 and 8 → `count` becomes 1, stays 4, and becomes 7 respectively. The expected pulse (`underflow` at `count=0`, `overflow` at `count=8`) fires.
- DEPTH=6: 20 writes interleaved with reads → pointers wrap at 5→0; data order preserved.
- `rst_n` pulsed low mid-burst with `count=5` → all outputs return to reset values asynchronously. A following write/read returns the new data.
